// File: rtl/line_memory_pkg.sv
// Shared constants and state encoding for the line-granular backing memory.
package line_memory_pkg;

    localparam int LINE_W      = 256;
    localparam int OFF_BITS    = 5;
    localparam int CNT_W       = 8;
    localparam int DEF_LATENCY = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/line_memory_array.sv
// Single-port line storage: one write enable, registered read, no reset.
module line_memory_array
    import line_memory_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [LINE_W-1:0]     wdata_i,
    output logic [LINE_W-1:0]     rdata_o
);

    logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Fixed-latency backing memory serving whole cache lines, one request at a time.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int LATENCY    = DEF_LATENCY,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    wr_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [LINE_W-1:0]       wdata_q;
    logic                    vld_q;

    logic [DEPTH_LOG2-1:0]   in_idx, req_idx;
    logic [LINE_W-1:0]       req_data, rdata;
    logic                    go_ack, req_wr, we, re;
    logic                    unused_addr;

    assign in_idx      = addr_i[OFF_BITS +: DEPTH_LOG2];
    assign unused_addr = ^{addr_i[31:OFF_BITS+DEPTH_LOG2],
                           addr_i[OFF_BITS-1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && enable_i) begin
                wr_q    <= write_i;
                idx_q   <= in_idx;
                wdata_q <= data_i;
            end
            if (re) begin
                vld_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the ACK edge is the accept edge, so use live inputs.
    always_comb begin
        ack_o    = (state_q == ACK);
        busy_o   = (state_q != IDLE);
        go_ack   = (state_d == ACK) && (state_q != ACK);
        req_wr   = (state_q == IDLE) ? write_i : wr_q;
        req_idx  = (state_q == IDLE) ? in_idx  : idx_q;
        req_data = (state_q == IDLE) ? data_i  : wdata_q;
        we       = go_ack & req_wr;
        re       = go_ack & ~req_wr;
    end

    // Before the first read ack after reset the array register is stale.
    assign data_o = vld_q ? rdata : '0;

    line_memory_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (we),
        .re_i   (re),
        .addr_i (req_idx),
        .wdata_i(req_data),
        .rdata_o(rdata)
    );

endmodule

// File: tb/tb_line_memory.sv
// Scoreboard bench for line_memory against an array-level reference model.
module tb_line_memory;

    localparam int L = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, wr = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] din = '0;
    logic         ack, busy;
    logic [255:0] dout;

    logic         en1 = 1'b0, wr1 = 1'b0;
    logic [31:0]  addr1 = '0;
    logic [255:0] din1 = '0;
    logic         ack1, busy1;
    logic [255:0] dout1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [255:0] data;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    logic [255:0] mdl [512];
    logic [255:0] mdl_dout = '0;

    line_memory #(.LATENCY(L), .DEPTH_LOG2(9)) dut (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en), .write_i(wr),
        .addr_i(addr), .data_i(din), .ack_o(ack), .data_o(dout),
        .busy_o(busy)
    );

    line_memory #(.LATENCY(1), .DEPTH_LOG2(9)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en1), .write_i(wr1),
        .addr_i(addr1), .data_i(din1), .ack_o(ack1), .data_o(dout1),
        .busy_o(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation.
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (rst_n && ack) begin
            if (prev_ack) chk("ack_consecutive", 1, 0);
            if (q.size() == 0) begin
                chk("spurious_ack", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_cycle", 256'(cyc), 256'(e.cyc));
                chk("ack_data", dout, e.data);
            end
        end
        prev_ack = rst_n && ack;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    // Issue one request; model decides the expected ack data and cycle.
    task automatic req(input logic w, input logic [31:0] a,
                       input logic [255:0] d, input bit churn);
        int idx, acc;
        exp_t e;
        wait_idle();
        en = 1'b1; wr = w; addr = a; din = d;
        @(posedge clk);
        #1;
        acc = cyc;
        idx = int'(a[13:5]);
        if (w) begin
            e.data = mdl_dout;
            mdl[idx] = d;
        end else begin
            e.data = mdl[idx];
            mdl_dout = mdl[idx];
        end
        e.cyc = acc + L - 1;
        q.push_back(e);
        @(negedge clk);
        chk("busy_after_accept", 256'(busy), 1);
        if (churn) begin
            for (int i = 1; i < L - 1; i++) begin
                en = 1'($urandom); wr = 1'($urandom);
                addr = $urandom; din = rnd256();
                @(negedge clk);
            end
        end
        en = 1'b0;
    endtask

    logic [255:0] old5;
    logic [255:0] pat1;
    int           acks, c0, c1;
    bit           p;

    initial begin
        #1;
        chk("rst_ack", 256'(ack), 0);
        chk("rst_busy", 256'(busy), 0);
        chk("rst_dout", dout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 512; i++)
            req(1'b1, 32'(i) << 5, (i == 5) ? 256'd0 : rnd256(), 1'b0);
        wait_idle();
        chk("dout_unchanged_by_writes", dout, 0);

        req(1'b1, 32'h60, {32{8'hA5}}, 1'b0);
        req(1'b0, 32'h60, '0, 1'b0);
        req(1'b1, 32'h100, {8{32'h12345678}}, 1'b0);
        req(1'b0, 32'h11F, '0, 1'b0);
        req(1'b1, 32'h4020, {16{16'hDEAD}}, 1'b0);
        req(1'b0, 32'h20, '0, 1'b0);
        req(1'b0, 32'h40, '0, 1'b1);
        repeat (5) @(negedge clk);
        chk("no_extra_ack_busy", 256'(busy), 0);

        // Abandon a pending write with an asynchronous reset.
        old5 = mdl[5];
        req(1'b1, 32'hA0, {256{1'b1}}, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ack", 256'(ack), 0);
        chk("midrst_busy", 256'(busy), 0);
        chk("midrst_dout", dout, 0);
        q.delete();
        mdl[5] = old5;
        mdl_dout = '0;
        @(negedge clk);
        rst_n = 1'b1;
        req(1'b0, 32'hA0, '0, 1'b0);

        for (int i = 0; i < 40; i++)
            req(1'($urandom), $urandom, rnd256(), 1'($urandom));
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", 256'(q.size()), 0);

        // LATENCY=1: back-to-back reads held on one enable.
        pat1 = rnd256();
        en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0; din1 = pat1;
        @(negedge clk);
        chk("l1_write_ack", 256'(ack1), 1);
        chk("l1_write_dout", dout1, 0);
        en1 = 1'b0;
        @(negedge clk);
        chk("l1_idle_ack", 256'(ack1), 0);
        en1 = 1'b1; wr1 = 1'b0;
        acks = 0; c0 = 0; c1 = 0; p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack1) begin
                if (p) chk("l1_consecutive", 1, 0);
                chk("l1_read_data", dout1, pat1);
                if (acks == 0) c0 = cyc; else c1 = cyc;
                acks++;
                if (acks == 2) en1 = 1'b0;
            end
            p = ack1;
        end
        chk("l1_ack_count", 256'(acks), 2);
        chk("l1_ack_spacing", 256'(c1 - c0), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
